// File: rtl/bus_arbiter_n.sv
// N-master bus arbiter: grants one master at a time, sequences ADDR/DATA phases
// against slave ready/response, and parks SPLIT masters until the slave releases them.

module bus_arb_split_cell (
  input  logic clk,
  input  logic rst,
  input  logic set_i,
  input  logic clr_i,
  output logic mask_o
);
  logic mask_q;

  // A SPLIT landing on the same edge as the release wins; the master stays parked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        mask_q <= 1'b0;
    else if (set_i) mask_q <= 1'b1;
    else if (clr_i) mask_q <= 1'b0;
  end

  assign mask_o = mask_q;
endmodule

module bus_arbiter_n #(
  parameter int NUM_MASTERS = 2,
  parameter int MODE        = 0,
  parameter int MAX_RETRY   = 3,
  parameter int OW          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] busreq,
  input  logic [NUM_MASTERS-1:0] rw_req,
  input  logic                   ready,
  input  logic [1:0]             response,
  input  logic [NUM_MASTERS-1:0] split_done,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [OW-1:0]          owner,
  output logic                   read_write,
  output logic                   busy,
  output logic                   error,
  output logic [NUM_MASTERS-1:0] split_mask
);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [1:0] RSP_ERROR = 2'b01;
  localparam logic [1:0] RSP_RETRY = 2'b10;
  localparam logic [1:0] RSP_SPLIT = 2'b11;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [OW-1:0]          owner_q, owner_d;
  logic [OW-1:0]          last_q, last_d;
  logic                   rw_q, rw_d;
  logic                   err_q, err_d;
  logic [RW-1:0]          retry_q, retry_d;
  logic [NUM_MASTERS-1:0] split_q, split_set;
  logic [NUM_MASTERS-1:0] elig, elig_rel;
  logic [OW-1:0]          win_idle, win_rel;

  function automatic logic [OW-1:0] pick(input logic [NUM_MASTERS-1:0] e,
                                         input logic [OW-1:0] last);
    logic [OW-1:0] w;
    logic          found;
    int            idx;
    w     = '0;
    found = 1'b0;
    if (MODE == 0) begin
      for (int i = NUM_MASTERS - 1; i >= 0; i--)
        if (e[i]) w = OW'(i);
    end else begin
      // Rotate: scan starting just after the previous owner, wrapping.
      for (int k = 1; k <= NUM_MASTERS; k++) begin
        idx = (int'(last) + k) % NUM_MASTERS;
        if (!found && e[idx]) begin
          w     = OW'(idx);
          found = 1'b1;
        end
      end
    end
    return w;
  endfunction

  function automatic logic [NUM_MASTERS-1:0] onehot(input logic [OW-1:0] i);
    return NUM_MASTERS'(1) << i;
  endfunction

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_split
    bus_arb_split_cell u_cell (
      .clk    (clk),
      .rst    (rst),
      .set_i  (split_set[g]),
      .clr_i  (split_done[g]),
      .mask_o (split_q[g])
    );
  end

  assign elig     = busreq & ~split_q;
  assign win_idle = pick(elig, last_q);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    last_d    = last_q;
    rw_d      = rw_q;
    retry_d   = retry_q;
    err_d     = 1'b0;
    split_set = '0;
    elig_rel  = '0;
    win_rel   = '0;
    case (state_q)
      IDLE: begin
        if (|elig) begin
          state_d = ADDR;
          owner_d = win_idle;
          grant_d = onehot(win_idle);
        end else begin
          grant_d = '0;
        end
      end
      ADDR: begin
        rw_d    = rw_req[owner_q];
        state_d = DATA;
      end
      DATA: begin
        if (ready) begin
          if (response == RSP_RETRY && retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            state_d = ADDR;
          end else begin
            retry_d = '0;
            last_d  = owner_q;
            err_d   = (response == RSP_ERROR) || (response == RSP_RETRY);
            if (response == RSP_SPLIT) split_set[owner_q] = 1'b1;
            // Re-arbitrate straight into ADDR; a freshly split owner is excluded now.
            elig_rel = busreq & ~(split_q | split_set);
            win_rel  = pick(elig_rel, owner_q);
            if (|elig_rel) begin
              state_d = ADDR;
              owner_d = win_rel;
              grant_d = onehot(win_rel);
            end else begin
              state_d = IDLE;
              grant_d = '0;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= OW'(NUM_MASTERS - 1);
      rw_q    <= 1'b0;
      err_q   <= 1'b0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      rw_q    <= rw_d;
      err_q   <= err_d;
      retry_q <= retry_d;
    end
  end

  assign grant      = grant_q;
  assign owner      = owner_q;
  assign read_write = rw_q;
  assign busy       = (state_q != IDLE);
  assign error      = err_q;
  assign split_mask = split_q;
endmodule

// File: tb/tb_bus_arbiter_n.sv
// Directed bench: a 2-master fixed-priority arbiter (a_*) and a 4-master round-robin one (b_*).
module tb_bus_arbiter_n;
  logic clk = 1'b0;
  logic rst;

  logic [1:0] a_busreq, a_rw_req, a_split_done, a_grant, a_split_mask;
  logic       a_ready, a_owner, a_read_write, a_busy, a_error;
  logic [1:0] a_response;

  logic [3:0] b_busreq, b_rw_req, b_split_done, b_grant, b_split_mask;
  logic       b_ready, b_read_write, b_busy, b_error;
  logic [1:0] b_response, b_owner;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         sel;
    logic [3:0] grant;
    logic [1:0] owner;
    logic       rw;
    logic       busy;
    logic       err;
    logic [3:0] split;
    string      tag;
  } exp_t;

  exp_t sb[$];

  bus_arbiter_n #(.NUM_MASTERS(2), .MODE(0), .MAX_RETRY(3)) u_dut_a (
    .clk(clk), .rst(rst), .busreq(a_busreq), .rw_req(a_rw_req), .ready(a_ready),
    .response(a_response), .split_done(a_split_done), .grant(a_grant), .owner(a_owner),
    .read_write(a_read_write), .busy(a_busy), .error(a_error), .split_mask(a_split_mask)
  );

  bus_arbiter_n #(.NUM_MASTERS(4), .MODE(1), .MAX_RETRY(3)) u_dut_b (
    .clk(clk), .rst(rst), .busreq(b_busreq), .rw_req(b_rw_req), .ready(b_ready),
    .response(b_response), .split_done(b_split_done), .grant(b_grant), .owner(b_owner),
    .read_write(b_read_write), .busy(b_busy), .error(b_error), .split_mask(b_split_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input string f, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s.%s: observed %0h expected %0h", tag, f, act, exp);
    end
  endtask

  task automatic compare_pop();
    exp_t e;
    logic [3:0] g, sm;
    logic [1:0] o;
    logic rw, bz, er;
    e = sb.pop_front();
    if (e.sel) begin
      g = b_grant; o = b_owner; rw = b_read_write; bz = b_busy; er = b_error; sm = b_split_mask;
    end else begin
      g = {2'b00, a_grant}; o = {1'b0, a_owner}; rw = a_read_write; bz = a_busy;
      er = a_error; sm = {2'b00, a_split_mask};
    end
    chk(e.tag, "grant", g, e.grant);
    chk(e.tag, "owner", {2'b00, o}, {2'b00, e.owner});
    chk(e.tag, "rw", {3'b000, rw}, {3'b000, e.rw});
    chk(e.tag, "busy", {3'b000, bz}, {3'b000, e.busy});
    chk(e.tag, "error", {3'b000, er}, {3'b000, e.err});
    chk(e.tag, "split", sm, e.split);
  endtask

  // Push the expectation for the state after the next edge, clock, then compare.
  task automatic step(input bit sel, input logic [3:0] g, input logic [1:0] o, input logic rw,
                      input logic bz, input logic er, input logic [3:0] sm, input string tag,
                      input bit now = 1'b0);
    exp_t e;
    e.sel = sel; e.grant = g; e.owner = o; e.rw = rw; e.busy = bz; e.err = er;
    e.split = sm; e.tag = tag;
    sb.push_back(e);
    if (!now) begin
      @(posedge clk);
      #1;
    end
    compare_pop();
  endtask

  task automatic set_a(input logic [1:0] br, input logic [1:0] rw, input logic rdy,
                       input logic [1:0] rsp, input logic [1:0] sd);
    a_busreq = br; a_rw_req = rw; a_ready = rdy; a_response = rsp; a_split_done = sd;
  endtask

  initial begin
    rst = 1'b1;
    set_a(2'b00, 2'b00, 1'b0, 2'b00, 2'b00);
    b_busreq = '0; b_rw_req = '0; b_ready = 1'b0; b_response = 2'b00; b_split_done = '0;
    #2;
    step(0, 4'b0000, 0, 0, 0, 0, 4'b0000, "a_reset", 1'b1);
    step(1, 4'b0000, 0, 0, 0, 0, 4'b0000, "b_reset", 1'b1);
    rst = 1'b0;

    // Fixed priority, back-to-back transfers, owner drops request mid-transfer
    set_a(2'b11, 2'b01, 1'b1, 2'b00, 2'b00);
    step(0, 4'b0001, 0, 0, 1, 0, 4'b0000, "t1_grant");
    step(0, 4'b0001, 0, 1, 1, 0, 4'b0000, "t1_data");
    step(0, 4'b0001, 0, 1, 1, 0, 4'b0000, "t1_regrant");
    a_busreq = 2'b10;
    step(0, 4'b0001, 0, 1, 1, 0, 4'b0000, "t1_hold");
    step(0, 4'b0010, 1, 1, 1, 0, 4'b0000, "t1_m1");
    step(0, 4'b0010, 1, 0, 1, 0, 4'b0000, "t1_m1_rd");
    a_busreq = 2'b00;
    step(0, 4'b0000, 1, 0, 0, 0, 4'b0000, "t1_idle");

    // Wait states: response ignored while ready is low
    set_a(2'b01, 2'b01, 1'b0, 2'b01, 2'b00);
    step(0, 4'b0001, 0, 0, 1, 0, 4'b0000, "t3_addr");
    for (int i = 0; i < 4; i++) step(0, 4'b0001, 0, 1, 1, 0, 4'b0000, "t3_wait");
    set_a(2'b00, 2'b01, 1'b1, 2'b00, 2'b00);
    step(0, 4'b0000, 0, 1, 0, 0, 4'b0000, "t3_done");

    // Three retries then OKAY: owner kept, no error
    set_a(2'b01, 2'b01, 1'b1, 2'b10, 2'b00);
    step(0, 4'b0001, 0, 1, 1, 0, 4'b0000, "t4_addr");
    for (int i = 0; i < 7; i++) step(0, 4'b0001, 0, 1, 1, 0, 4'b0000, "t4_retry");
    set_a(2'b00, 2'b01, 1'b1, 2'b00, 2'b00);
    step(0, 4'b0000, 0, 1, 0, 0, 4'b0000, "t4_ok");
    // Fourth consecutive retry aborts with an error pulse
    set_a(2'b01, 2'b01, 1'b1, 2'b10, 2'b00);
    step(0, 4'b0001, 0, 1, 1, 0, 4'b0000, "t4b_addr");
    for (int i = 0; i < 7; i++) step(0, 4'b0001, 0, 1, 1, 0, 4'b0000, "t4b_retry");
    a_busreq = 2'b00;
    step(0, 4'b0000, 0, 1, 0, 1, 4'b0000, "t4b_abort");
    a_response = 2'b00;
    step(0, 4'b0000, 0, 1, 0, 0, 4'b0000, "t4b_err_clr");

    // SPLIT parking, release, set-wins collision, all-split idle
    set_a(2'b11, 2'b01, 1'b1, 2'b00, 2'b00);
    step(0, 4'b0001, 0, 1, 1, 0, 4'b0000, "t5_addr");
    step(0, 4'b0001, 0, 1, 1, 0, 4'b0000, "t5_data");
    a_response = 2'b11;
    step(0, 4'b0010, 1, 1, 1, 0, 4'b0001, "t5_split");
    a_response = 2'b00; a_ready = 1'b0;
    step(0, 4'b0010, 1, 0, 1, 0, 4'b0001, "t5_m1_data");
    a_split_done = 2'b01;
    step(0, 4'b0010, 1, 0, 1, 0, 4'b0000, "t5_release");
    a_split_done = 2'b00; a_ready = 1'b1;
    step(0, 4'b0001, 0, 0, 1, 0, 4'b0000, "t5_m0_back");
    step(0, 4'b0001, 0, 1, 1, 0, 4'b0000, "t5_m0_data");
    a_response = 2'b11; a_split_done = 2'b01;
    step(0, 4'b0010, 1, 1, 1, 0, 4'b0001, "t5_set_wins");
    a_response = 2'b00; a_split_done = 2'b00;
    step(0, 4'b0010, 1, 0, 1, 0, 4'b0001, "t5_m1_data2");
    a_response = 2'b11;
    step(0, 4'b0000, 1, 0, 0, 0, 4'b0011, "t5_all_split");
    a_response = 2'b00;
    step(0, 4'b0000, 1, 0, 0, 0, 4'b0011, "t5_park");
    step(0, 4'b0000, 1, 0, 0, 0, 4'b0011, "t5_park");
    a_split_done = 2'b10;
    step(0, 4'b0000, 1, 0, 0, 0, 4'b0001, "t5_clear1");
    a_split_done = 2'b00;
    step(0, 4'b0010, 1, 0, 1, 0, 4'b0001, "t5_m1_regrant");
    a_ready = 1'b0;
    step(0, 4'b0010, 1, 0, 1, 0, 4'b0001, "t6_m1_data");

    // Asynchronous reset in the middle of DATA
    #3 rst = 1'b1;
    #1;
    step(0, 4'b0000, 0, 0, 0, 0, 4'b0000, "t6_rst", 1'b1);
    rst = 1'b0;
    set_a(2'b10, 2'b00, 1'b0, 2'b00, 2'b00);
    step(0, 4'b0010, 1, 0, 1, 0, 4'b0000, "t6_after");
    a_busreq = 2'b00;

    // Round-robin over four masters, no idle gaps, then skip and wrap
    b_busreq = 4'b1111; b_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(1, 4'b0001 << (k % 4), 2'(k % 4), 0, 1, 0, 4'b0000, "t2_rr_addr");
      step(1, 4'b0001 << (k % 4), 2'(k % 4), 0, 1, 0, 4'b0000, "t2_rr_data");
    end
    b_busreq = 4'b1001;
    step(1, 4'b1000, 3, 0, 1, 0, 4'b0000, "t2_skip");
    step(1, 4'b1000, 3, 0, 1, 0, 4'b0000, "t2_skip_data");
    step(1, 4'b0001, 0, 0, 1, 0, 4'b0000, "t2_wrap");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
